lc3_bypass_history: RTL and testbench
=====================================

// Module: lc3_bypass_history
// PURPOSE
//   Parametrised writeback-history bypass unit for the LC-3 pipeline. Keeps the last DEPTH retired
//   register and memory writes, and forwards the youngest matching value to NUM_RD register read
//   ports and one load port. Sits between the regfile/mem outputs and the execute stage.
//   Generalises the fixed two-deep reg/mem previous-write forwarding. Adds per-port hit flags,
//   an occupancy count and a saturating hit counter.
// PARAMETERS
//   DATA_W   16  datapath width
//   REG_AW   3   register index width
//   MEM_AW   16  memory address width
//   DEPTH    2   history entries (>=1), entry 0 = youngest
//   NUM_RD   2   register read ports (>=1)
//   MEM_FWD  1   1 = store/forward memory writes, 0 = memory path pass-through
//   CNT_W    16  hit counter width
// PORTS
//   clk          in   1              rising-edge clock
//   rst_n        in   1              async active-low reset
//   advance      in   1              pipeline advances this cycle (0 = stall, hold history)
//   wr_valid     in   1              register write retiring this cycle
//   wr_reg       in   REG_AW         destination register
//   wr_data      in   DATA_W         value written
//   wm_valid     in   1              memory write retiring this cycle
//   wm_addr      in   MEM_AW         store address
//   wm_data      in   DATA_W         store data
//   rd_reg       in   NUM_RD*REG_AW  read register per port (port p at [p*REG_AW +: REG_AW])
//   rd_rf_data   in   NUM_RD*DATA_W  regfile output per port
//   rd_data      out  NUM_RD*DATA_W  forwarded value per port
//   rd_hit       out  NUM_RD         port value came from bypass
//   ld_addr      in   MEM_AW         load address
//   ld_mem_data  in   DATA_W         memory output for ld_addr
//   ld_data      out  DATA_W         forwarded load value
//   ld_hit       out  1              load value came from bypass
//   occ          out  $clog2(DEPTH+1) number of valid history entries (reg or mem)
//   hit_cnt      out  CNT_W          saturating count of hit cycles
//   cnt_clr      in   1              synchronous clear of hit_cnt
// BEHAVIOUR
// - Reset (async, rst_n=0): all entries invalid, entry data/addr 0, hit_cnt=0, occ=0.
//   Outputs are then pure pass-through: rd_data=rd_rf_data, ld_data=ld_mem_data, hits 0.
//   Reset mid-operation takes effect immediately, without waiting for a clock edge.
// - History update on posedge clk, only when advance=1:
//   entry[i]<=entry[i-1] for i>=1, entry[0]<=current write (reg valid/reg/data, mem valid/addr/data).
//   With no write, an invalid bubble shifts in, so entries age out after DEPTH advances.
//   advance=0: history frozen, wr_valid/wm_valid ignored (stall cycles carry no retire).
// - Register lookup per port, combinational; priority youngest first:
//   current write (wr_valid && wr_reg==rd_reg) > entry0 > ... > entry[DEPTH-1] > rd_rf_data.
//   rd_hit[p]=1 iff any bypass source matched. R0 gets no special treatment (LC-3 R0 is a real register).
// - Memory lookup uses the same priority on wm_* / mem entries, matching on the full MEM_AW address.
//   MEM_FWD=0: mem fields are not stored, ld_data=ld_mem_data, ld_hit=0.
// - Reg and mem halves of an entry are independent. One entry can carry both (valid bits separate).
// - occ counts entries with reg-valid or mem-valid set. It is registered and changes only on advance or reset.
// - hit_cnt: on posedge with advance=1 and (|rd_hit || ld_hit), +1, saturating at 2^CNT_W-1.
//   cnt_clr=1 forces 0 and takes priority over a simultaneous increment.
// - Latency: lookups 0 cycles, combinational from state and inputs. A write is visible via
//   history from the cycle after its advance, for exactly DEPTH advancing cycles.
// - All arithmetic is unsigned. Compares are exact equality. There is no wrap on occ (max DEPTH).
// TESTING
// 1 Reset, rd_rf_data=0x1234 on all ports -> rd_data=0x1234, rd_hit=0, occ=0, hit_cnt=0.
// 2 DEPTH=2: wr R3=0x00AA (adv), then 2 idle adv, rf=0. Read R3 gives 0x00AA for 2 cycles, then 0x0000.
//   occ goes 1,1,0.
// 3 wr R1=5, then wr R1=7 (adv each) -> read R1=7. Same cycle wr_valid R1=9 -> 9, rd_hit=1.
// 4 Write R2=0x55, then advance=0 for 3 cycles with wr_valid R2=0x66 -> R2 reads 0x55 (from entry0).
//   The stalled 0x66 is ignored except as the current-write source, and occ holds.
// 5 MEM_FWD=1: store 0x3000<-0xBEEF, next cycle load 0x3000 with ld_mem_data=0 -> 0xBEEF, ld_hit=1.
//   MEM_FWD=0 -> 0x0000, ld_hit=0.
// 6 CNT_W=4: 20 hit cycles -> hit_cnt=15. cnt_clr with a hit -> 0.
//   rst_n low mid-cycle -> occ=0 and pass-through at once.

Source files
------------

// File: rtl/lc3_bypass_history_if.sv
// Signal bundle between the LC-3 pipeline and the writeback-history bypass unit.
// master = pipeline side (retires writes, issues lookups), slave = bypass unit.
interface lc3_bypass_history_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int MEM_AW = 16,
   parameter int DEPTH  = 2,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 16
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   // No ready path: wr_valid/wm_valid retire in the cycle they are presented and are
   // qualified by advance; lookups are answered combinationally in the same cycle.
   logic                     advance;
   logic                     wr_valid;
   logic [REG_AW-1:0]        wr_reg;
   logic [DATA_W-1:0]        wr_data;
   logic                     wm_valid;
   logic [MEM_AW-1:0]        wm_addr;
   logic [DATA_W-1:0]        wm_data;
   logic [NUM_RD*REG_AW-1:0] rd_reg;
   logic [NUM_RD*DATA_W-1:0] rd_rf_data;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_hit;
   logic [MEM_AW-1:0]        ld_addr;
   logic [DATA_W-1:0]        ld_mem_data;
   logic [DATA_W-1:0]        ld_data;
   logic                     ld_hit;
   logic [OCC_W-1:0]         occ;
   logic [CNT_W-1:0]         hit_cnt;
   logic                     cnt_clr;

   modport master (
      output advance, wr_valid, wr_reg, wr_data, wm_valid, wm_addr, wm_data,
      output rd_reg, rd_rf_data, ld_addr, ld_mem_data, cnt_clr,
      input  rd_data, rd_hit, ld_data, ld_hit, occ, hit_cnt
   );

   modport slave (
      input  advance, wr_valid, wr_reg, wr_data, wm_valid, wm_addr, wm_data,
      input  rd_reg, rd_rf_data, ld_addr, ld_mem_data, cnt_clr,
      output rd_data, rd_hit, ld_data, ld_hit, occ, hit_cnt
   );
endinterface

// File: rtl/lc3_bypass_history.sv
// Writeback-history bypass for the LC-3 pipeline: keeps the last DEPTH retired reg/mem writes
// and forwards the youngest match to each register read port and the load port.
module lc3_bypass_history #(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 3,
   parameter int MEM_AW  = 16,
   parameter int DEPTH   = 2,
   parameter int NUM_RD  = 2,
   parameter int MEM_FWD = 1,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                rst_n,
   lc3_bypass_history_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]         regValid;
   logic [REG_AW-1:0]        regIdx  [DEPTH];
   logic [DATA_W-1:0]        regData [DEPTH];
   logic [DEPTH-1:0]         memValid;
   logic [MEM_AW-1:0]        memAddr [DEPTH];
   logic [DATA_W-1:0]        memData [DEPTH];
   logic [OCC_W-1:0]         occ;
   logic [OCC_W-1:0]         occNext;
   logic [CNT_W-1:0]         hitCnt;
   logic                     wmStore;
   logic                     wrLive;
   logic                     wmLive;
   logic [NUM_RD-1:0]        rdHit;
   logic [NUM_RD*DATA_W-1:0] rdData;
   logic                     ldHit;
   logic [DATA_W-1:0]        ldData;

   // With MEM_FWD=0 the memory half of every entry stays empty.
   assign wmStore = (MEM_FWD != 0) && bus.wm_valid;
   // Current-cycle sources are muted during reset so outputs are pure pass-through.
   assign wrLive  = bus.wr_valid && rst_n;
   assign wmLive  = wmStore && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regValid <= '0;
         memValid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regIdx[i]  <= '0;
            regData[i] <= '0;
            memAddr[i] <= '0;
            memData[i] <= '0;
         end
      end else if (bus.advance) begin
         for (int i = DEPTH - 1; i >= 1; i--) begin
            regValid[i] <= regValid[i-1];
            regIdx[i]   <= regIdx[i-1];
            regData[i]  <= regData[i-1];
            memValid[i] <= memValid[i-1];
            memAddr[i]  <= memAddr[i-1];
            memData[i]  <= memData[i-1];
         end
         regValid[0] <= bus.wr_valid;
         regIdx[0]   <= bus.wr_reg;
         regData[0]  <= bus.wr_data;
         memValid[0] <= wmStore;
         memAddr[0]  <= (MEM_FWD != 0) ? bus.wm_addr : '0;
         memData[0]  <= (MEM_FWD != 0) ? bus.wm_data : '0;
      end
   end

   // Occupancy after the shift: the new head plus every entry that survives one more step.
   always_comb begin
      occNext = '0;
      if (bus.wr_valid || wmStore) occNext = occNext + OCC_W'(1);
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (regValid[i] || memValid[i]) occNext = occNext + OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
      end else if (bus.advance) begin
         occ <= occNext;
      end
   end

   // Oldest source is applied first so each younger match overrides it.
   always_comb begin
      rdHit  = '0;
      rdData = bus.rd_rf_data;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (regValid[i] && (regIdx[i] == bus.rd_reg[p*REG_AW +: REG_AW])) begin
               rdHit[p]                    = 1'b1;
               rdData[p*DATA_W +: DATA_W] = regData[i];
            end
         end
         if (wrLive && (bus.wr_reg == bus.rd_reg[p*REG_AW +: REG_AW])) begin
            rdHit[p]                    = 1'b1;
            rdData[p*DATA_W +: DATA_W] = bus.wr_data;
         end
      end
   end

   always_comb begin
      ldHit  = 1'b0;
      ldData = bus.ld_mem_data;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (memValid[i] && (memAddr[i] == bus.ld_addr)) begin
            ldHit  = 1'b1;
            ldData = memData[i];
         end
      end
      if (wmLive && (bus.wm_addr == bus.ld_addr)) begin
         ldHit  = 1'b1;
         ldData = bus.wm_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hitCnt <= '0;
      end else if (bus.cnt_clr) begin
         hitCnt <= '0;
      end else if (bus.advance && ((|rdHit) || ldHit) && (hitCnt != '1)) begin
         hitCnt <= hitCnt + CNT_W'(1);
      end
   end

   assign bus.rd_data = rdData;
   assign bus.rd_hit  = rdHit;
   assign bus.ld_data = ldData;
   assign bus.ld_hit  = ldHit;
   assign bus.occ     = occ;
   assign bus.hit_cnt = hitCnt;
endmodule

// File: tb/tb_lc3_bypass_history.sv
// Directed bench for lc3_bypass_history: vector table on a MEM_FWD=1 instance, plus
// hand sequences for MEM_FWD=0, counter saturation/clear and asynchronous reset.
module tb_lc3_bypass_history;
   logic clk;
   logic rst_n;
   int   passCnt;
   int   totalCnt;

   lc3_bypass_history_if #(.CNT_W(16)) busA ();
   lc3_bypass_history_if #(.CNT_W(4))  busB ();

   lc3_bypass_history #(.MEM_FWD(1), .CNT_W(16)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
   lc3_bypass_history #(.MEM_FWD(0), .CNT_W(4))  dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        adv;
      logic        wrV;
      logic [2:0]  wrReg;
      logic [15:0] wrData;
      logic        wmV;
      logic [15:0] wmAddr;
      logic [15:0] wmData;
      logic [2:0]  rd0;
      logic [2:0]  rd1;
      logic [15:0] rf0;
      logic [15:0] rf1;
      logic [15:0] ldA;
      logic [15:0] ldM;
      logic [15:0] eD0;
      logic [15:0] eD1;
      logic [1:0]  eHit;
      logic [15:0] eLd;
      logic        eLdHit;
      logic [1:0]  eOcc;
      logic [15:0] eCnt;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic idleA();
      busA.advance = 0; busA.wr_valid = 0; busA.wr_reg = 0; busA.wr_data = 0;
      busA.wm_valid = 0; busA.wm_addr = 0; busA.wm_data = 0; busA.rd_reg = 0;
      busA.rd_rf_data = 0; busA.ld_addr = 0; busA.ld_mem_data = 0; busA.cnt_clr = 0;
   endtask

   task automatic idleB();
      busB.advance = 0; busB.wr_valid = 0; busB.wr_reg = 0; busB.wr_data = 0;
      busB.wm_valid = 0; busB.wm_addr = 0; busB.wm_data = 0; busB.rd_reg = 0;
      busB.rd_rf_data = 0; busB.ld_addr = 0; busB.ld_mem_data = 0; busB.cnt_clr = 0;
   endtask

   task automatic applyA(input vec_t v);
      busA.advance     = v.adv;
      busA.wr_valid    = v.wrV;
      busA.wr_reg      = v.wrReg;
      busA.wr_data     = v.wrData;
      busA.wm_valid    = v.wmV;
      busA.wm_addr     = v.wmAddr;
      busA.wm_data     = v.wmData;
      busA.rd_reg      = {v.rd1, v.rd0};
      busA.rd_rf_data  = {v.rf1, v.rf0};
      busA.ld_addr     = v.ldA;
      busA.ld_mem_data = v.ldM;
      busA.cnt_clr     = 1'b0;
   endtask

   initial begin
      passCnt  = 0;
      totalCnt = 0;
      // adv wrV reg data | wmV addr data | rd0 rd1 rf0 rf1 | ldA ldM | eD0 eD1 eHit eLd eLdHit eOcc eCnt
      vecs[0]  = '{1'b1, 1'b1, 3'd3, 16'h00AA, 1'b0, 16'h0, 16'h0, 3'd3, 3'd4, 16'h0000, 16'h1111,
                   16'h0010, 16'h2222, 16'h00AA, 16'h1111, 2'b01, 16'h2222, 1'b0, 2'd0, 16'd0};
      vecs[1]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd3, 3'd3, 16'h0000, 16'h0000,
                   16'h0010, 16'h2222, 16'h00AA, 16'h00AA, 2'b11, 16'h2222, 1'b0, 2'd1, 16'd1};
      vecs[2]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd3, 3'd3, 16'h0000, 16'h0000,
                   16'h0010, 16'h2222, 16'h00AA, 16'h00AA, 2'b11, 16'h2222, 1'b0, 2'd1, 16'd2};
      vecs[3]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd3, 3'd3, 16'h0000, 16'h0000,
                   16'h0010, 16'h2222, 16'h0000, 16'h0000, 2'b00, 16'h2222, 1'b0, 2'd0, 16'd3};
      vecs[4]  = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b0, 16'h0, 16'h0, 3'd1, 3'd2, 16'h0101, 16'h0202,
                   16'h0010, 16'h2222, 16'h0005, 16'h0202, 2'b01, 16'h2222, 1'b0, 2'd0, 16'd3};
      vecs[5]  = '{1'b1, 1'b1, 3'd1, 16'h0007, 1'b0, 16'h0, 16'h0, 3'd1, 3'd1, 16'h0101, 16'h0202,
                   16'h0010, 16'h2222, 16'h0007, 16'h0007, 2'b11, 16'h2222, 1'b0, 2'd1, 16'd4};
      vecs[6]  = '{1'b0, 1'b1, 3'd1, 16'h0009, 1'b0, 16'h0, 16'h0, 3'd1, 3'd0, 16'h0101, 16'h0F0F,
                   16'h0010, 16'h2222, 16'h0009, 16'h0F0F, 2'b01, 16'h2222, 1'b0, 2'd2, 16'd5};
      vecs[7]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd1, 3'd0, 16'h0101, 16'h0F0F,
                   16'h0010, 16'h2222, 16'h0007, 16'h0F0F, 2'b01, 16'h2222, 1'b0, 2'd2, 16'd5};
      vecs[8]  = '{1'b1, 1'b1, 3'd0, 16'h0A0A, 1'b0, 16'h0, 16'h0, 3'd0, 3'd1, 16'h0101, 16'h0F0F,
                   16'h0010, 16'h2222, 16'h0A0A, 16'h0007, 2'b11, 16'h2222, 1'b0, 2'd1, 16'd6};
      vecs[9]  = '{1'b1, 1'b1, 3'd2, 16'h0055, 1'b0, 16'h0, 16'h0, 3'd2, 3'd0, 16'h0000, 16'h0000,
                   16'h0010, 16'h2222, 16'h0055, 16'h0A0A, 2'b11, 16'h2222, 1'b0, 2'd1, 16'd7};
      vecs[10] = '{1'b0, 1'b1, 3'd2, 16'h0066, 1'b0, 16'h0, 16'h0, 3'd2, 3'd5, 16'h0000, 16'h5555,
                   16'h0010, 16'h2222, 16'h0066, 16'h5555, 2'b01, 16'h2222, 1'b0, 2'd2, 16'd8};
      vecs[11] = '{1'b0, 1'b1, 3'd2, 16'h0066, 1'b0, 16'h0, 16'h0, 3'd2, 3'd5, 16'h0000, 16'h5555,
                   16'h0010, 16'h2222, 16'h0066, 16'h5555, 2'b01, 16'h2222, 1'b0, 2'd2, 16'd8};
      vecs[12] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd2, 3'd5, 16'h0000, 16'h5555,
                   16'h0010, 16'h2222, 16'h0055, 16'h5555, 2'b01, 16'h2222, 1'b0, 2'd2, 16'd8};
      vecs[13] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h3000, 16'hBEEF, 3'd6, 3'd7, 16'h0006, 16'h0007,
                   16'h3000, 16'h0000, 16'h0006, 16'h0007, 2'b00, 16'hBEEF, 1'b1, 2'd2, 16'd8};
      vecs[14] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd2, 3'd7, 16'h0000, 16'h0007,
                   16'h3000, 16'h0000, 16'h0055, 16'h0007, 2'b01, 16'hBEEF, 1'b1, 2'd2, 16'd9};
      vecs[15] = '{1'b1, 1'b1, 3'd7, 16'h7777, 1'b1, 16'h3001, 16'h1234, 3'd7, 3'd2, 16'h0000, 16'h0002,
                   16'h3000, 16'h00FF, 16'h7777, 16'h0002, 2'b01, 16'hBEEF, 1'b1, 2'd1, 16'd10};
      vecs[16] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd7, 3'd3, 16'h0000, 16'h0003,
                   16'h3001, 16'h0000, 16'h7777, 16'h0003, 2'b01, 16'h1234, 1'b1, 2'd1, 16'd11};
      vecs[17] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd7, 3'd1, 16'h0000, 16'h0011,
                   16'hB001, 16'h4444, 16'h7777, 16'h0011, 2'b01, 16'h4444, 1'b0, 2'd1, 16'd12};
      vecs[18] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 3'd7, 3'd1, 16'h00F7, 16'h0011,
                   16'h3001, 16'h0055, 16'h00F7, 16'h0011, 2'b00, 16'h0055, 1'b0, 2'd0, 16'd13};

      // Reset state and pass-through
      rst_n = 1'b0;
      idleA();
      idleB();
      busA.rd_rf_data = {16'h1234, 16'h1234};
      #2;
      check("reset_rd_data", busA.rd_data, 32'h1234_1234);
      check("reset_rd_hit", busA.rd_hit, 0);
      check("reset_occ", busA.occ, 0);
      check("reset_hit_cnt", busA.hit_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         applyA(vecs[k]);
         #1;
         check($sformatf("v%0d_rd_data", k), busA.rd_data, {vecs[k].eD1, vecs[k].eD0});
         check($sformatf("v%0d_rd_hit", k), busA.rd_hit, vecs[k].eHit);
         check($sformatf("v%0d_ld_data", k), busA.ld_data, vecs[k].eLd);
         check($sformatf("v%0d_ld_hit", k), busA.ld_hit, vecs[k].eLdHit);
         check($sformatf("v%0d_occ", k), busA.occ, vecs[k].eOcc);
         check($sformatf("v%0d_hit_cnt", k), busA.hit_cnt, vecs[k].eCnt);
      end

      // cnt_clr wins over a simultaneous hit increment
      @(negedge clk);
      idleA();
      busA.advance = 1; busA.wr_valid = 1; busA.wr_reg = 3'd1; busA.wr_data = 16'h0001;
      busA.rd_reg = {3'd0, 3'd1}; busA.cnt_clr = 1;
      #1;
      check("clr_pre_cnt", busA.hit_cnt, 13);
      check("clr_pre_hit", busA.rd_hit, 2'b01);
      @(negedge clk);
      idleA();
      #1;
      check("clr_post_cnt", busA.hit_cnt, 0);

      // MEM_FWD=0: stores never forward
      @(negedge clk);
      busB.advance = 1; busB.wm_valid = 1; busB.wm_addr = 16'h3000; busB.wm_data = 16'hBEEF;
      busB.ld_addr = 16'h3000; busB.ld_mem_data = 16'h0000; busB.rd_reg = {3'd7, 3'd6};
      #1;
      check("nofwd_same_ld_data", busB.ld_data, 0);
      check("nofwd_same_ld_hit", busB.ld_hit, 0);
      @(negedge clk);
      busB.wm_valid = 0;
      #1;
      check("nofwd_next_ld_data", busB.ld_data, 0);
      check("nofwd_next_ld_hit", busB.ld_hit, 0);
      check("nofwd_hit_cnt", busB.hit_cnt, 0);

      // CNT_W=4 saturation over 20 hit cycles
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         busB.advance = 1; busB.wr_valid = 1; busB.wr_reg = 3'd1; busB.wr_data = 16'(k);
         busB.rd_reg = {3'd0, 3'd1};
         #1;
         if (k == 10) check("sat_cnt_10", busB.hit_cnt, 10);
         if (k == 15) check("sat_cnt_15", busB.hit_cnt, 15);
      end
      @(negedge clk);
      idleB();
      #1;
      check("sat_cnt_final", busB.hit_cnt, 15);
      @(negedge clk);
      busB.advance = 1; busB.wr_valid = 1; busB.wr_reg = 3'd1; busB.rd_reg = {3'd0, 3'd1};
      busB.cnt_clr = 1;
      #1;
      check("sat_clr_hit", busB.rd_hit, 2'b01);
      @(negedge clk);
      idleB();
      #1;
      check("sat_clr_cnt", busB.hit_cnt, 0);

      // Asynchronous reset in the middle of a cycle
      @(negedge clk);
      busA.advance = 1; busA.wr_valid = 1; busA.wr_reg = 3'd4; busA.wr_data = 16'h4444;
      busA.rd_reg = {3'd1, 3'd4}; busA.rd_rf_data = {16'h2222, 16'h1234};
      @(negedge clk);
      busA.advance = 0; busA.wr_valid = 0;
      #1;
      check("prerst_rd_data", busA.rd_data, {16'h0001, 16'h4444});
      check("prerst_occ", busA.occ, 2);
      check("prerst_hit_cnt", busA.hit_cnt, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_occ", busA.occ, 0);
      check("midrst_rd_data", busA.rd_data, {16'h2222, 16'h1234});
      check("midrst_rd_hit", busA.rd_hit, 0);
      check("midrst_hit_cnt", busA.hit_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
